// File: rtl/equiv_sweep_pkg.sv
// equiv_sweep_pkg: shared types and constant helpers for the equivalence
// sweep controller.
//   state_e  - controller FSM state (2-bit encoding)
//   last_vec - all-ones vector value for an n-bit input sweep
//   sat_max  - saturation value of a w-bit counter
package equiv_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int unsigned last_vec(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/equiv_sweep_ctrl_if.sv
// equiv_sweep_ctrl_if: bundle between the test harness / function pair
// (master) and the sweep controller (slave).
//   start, abort            harness -> controller
//   f_orig, f_min           function pair -> controller
//   vec_out                 controller -> function pair (shared inputs)
//   busy, done, pass,
//   mism_cnt, first_fail_*  controller -> harness
interface equiv_sweep_ctrl_if #(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4
);
  logic             start;
  logic             abort;
  logic             f_orig;
  logic             f_min;
  logic [N_IN-1:0]  vec_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mism_cnt;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, abort, f_orig, f_min,
    input  vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, abort, f_orig, f_min,
    output vec_out, busy, done, pass, mism_cnt, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear and enable that
// sticks at its maximum value instead of wrapping.
//   clk, rst_n  clock, async active-low reset
//   clr         sync clear (wins over en)
//   en          increment request
//   cnt         current count
module sat_counter
  import equiv_sweep_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  localparam logic [W-1:0] MAX = W'(sat_max(W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && (cnt != MAX))  cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/equiv_sweep_ctrl.sv
// equiv_sweep_ctrl: exhaustively drives all 2^N_IN vectors into an
// original/minimized function pair, compares the two outputs per vector,
// counts mismatches (saturating), captures the first failing vector and
// reports pass/fail with a start/done handshake.
// Each vector gets one settle cycle (DRIVE) then one compare cycle (SAMPLE).
//   clk, rst_n  clock, async active-low reset
//   bus         equiv_sweep_ctrl_if.slave (start/abort in, f_orig/f_min in,
//               vec_out, busy, done, pass, mism_cnt, first_fail_* out)
// Build option: EQUIV_STOP_ON_FAIL_EN - end the sweep on the first mismatch.
module equiv_sweep_ctrl
  import equiv_sweep_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  equiv_sweep_ctrl_if.slave bus
);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(last_vec(N_IN));

`ifdef EQUIV_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_e           state, nxt;
  logic [N_IN-1:0]  vec_q, ffv_q;
  logic             ffval_q, pass_q;
  logic [CNT_W-1:0] cnt;
  logic             mism, last;
  logic             clr, smp, cnt_en, step, finish, busy, done;

  assign mism = bus.f_orig ^ bus.f_min;
  assign last = (vec_q == LAST_VEC);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next state; abort only matters while sweeping, start only in IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (bus.start) nxt = DRIVE;
      DRIVE:  nxt = bus.abort ? IDLE : SAMPLE;
      SAMPLE: begin
        if (bus.abort)                     nxt = IDLE;
        else if (last)                     nxt = DONE;
        else if (STOP_ON_FAIL && mism)     nxt = DONE;
        else                               nxt = DRIVE;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs / datapath strobes; an aborted SAMPLE updates nothing
  always_comb begin
    busy   = (state == DRIVE) || (state == SAMPLE);
    done   = (state == DONE);
    clr    = (state == IDLE) && bus.start;
    smp    = (state == SAMPLE) && !bus.abort;
    cnt_en = smp && mism;
    step   = smp && (nxt == DRIVE);
    finish = smp && (nxt == DONE);
  end

  sat_counter #(.W(CNT_W)) u_mism_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (cnt_en),
    .cnt   (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else if (clr) begin
      vec_q   <= '0;
      ffv_q   <= '0;
      ffval_q <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      if (step) vec_q <= vec_q + N_IN'(1);
      if (cnt_en && !ffval_q) begin
        ffv_q   <= vec_q;
        ffval_q <= 1'b1;
      end
      // cnt does not yet include this cycle's compare, so fold it in
      if (finish) pass_q <= (cnt == '0) && !mism;
    end
  end

  assign bus.vec_out          = vec_q;
  assign bus.busy             = busy;
  assign bus.done             = done;
  assign bus.pass             = pass_q;
  assign bus.mism_cnt         = cnt;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffval_q;
endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// tb_equiv_sweep_ctrl: scoreboard bench. Stimulus pushes the expected
// completion record per sweep; negedge monitors pop and compare on done and
// check vec_out stepping. dut uses CNT_W=4, dut2 uses CNT_W=2.
module tb_equiv_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  equiv_sweep_ctrl_if #(.N_IN(3), .CNT_W(4)) b1();
  equiv_sweep_ctrl_if #(.N_IN(3), .CNT_W(2)) b2();

  equiv_sweep_ctrl #(.N_IN(3), .CNT_W(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  equiv_sweep_ctrl #(.N_IN(3), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  typedef struct {
    int lat;
    int pass;
    int cnt;
    int ffv;
    int ffval;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   c1 = 0;
  int   c2 = 0;
  bit   chk_vec = 1'b0;
  int   mode = 0;

  // f_orig = AB + AB'C ; bit2=A bit1=B bit0=C
  function automatic logic fo(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & ~v[1] & v[0]);
  endfunction

  // 0: f_min = A(B+C), 1: stuck-at-0, 2: inverted original
  function automatic logic fm(input int md, input logic [2:0] v);
    case (md)
      1:       return 1'b0;
      2:       return ~fo(v);
      default: return v[2] & (v[1] | v[0]);
    endcase
  endfunction

  assign b1.f_orig = fo(b1.vec_out);
  assign b1.f_min  = fm(mode, b1.vec_out);
  assign b2.f_orig = fo(b2.vec_out);
  assign b2.f_min  = fm(mode, b2.vec_out);

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor dut
  always @(negedge clk) begin
    if (rst_n && chk_vec && b1.busy)
      chk("vec_out_step", int'(b1.vec_out), (cyc - c1) / 2);
    if (b1.done) begin
      if (q1.size() == 0) chk("done1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("done1_latency", cyc - c1 + 1, e1.lat);
        chk("done1_pass",    int'(b1.pass), e1.pass);
        chk("done1_cnt",     int'(b1.mism_cnt), e1.cnt);
        chk("done1_ffvalid", int'(b1.first_fail_valid), e1.ffval);
        chk("done1_ffvec",   int'(b1.first_fail_vec), e1.ffv);
      end
    end
  end

  // monitor dut2
  always @(negedge clk) begin
    if (b2.done) begin
      if (q2.size() == 0) chk("done2_unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("done2_latency", cyc - c2 + 1, e2.lat);
        chk("done2_pass",    int'(b2.pass), e2.pass);
        chk("done2_cnt",     int'(b2.mism_cnt), e2.cnt);
        chk("done2_ffvalid", int'(b2.first_fail_valid), e2.ffval);
        chk("done2_ffvec",   int'(b2.first_fail_vec), e2.ffv);
      end
    end
  end

  task automatic go1(input bit ab, input bit push, input exp_t e);
    chk_vec = 1'b0;
    @(negedge clk);
    b1.start = 1'b1;
    b1.abort = ab;
    @(negedge clk);
    b1.start = 1'b0;
    b1.abort = 1'b0;
    c1 = cyc;
    if (push) q1.push_back(e);
    chk_vec = 1'b1;
  endtask

  task automatic go2(input exp_t e);
    @(negedge clk);
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    c2 = cyc;
    q2.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q2.size() != 0) begin
      chk("done_timeout", q1.size() + q2.size(), 0);
      q1.delete();
      q2.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vec"},   int'(b1.vec_out), 0);
    chk({nm, "_busy"},  int'(b1.busy), 0);
    chk({nm, "_done"},  int'(b1.done), 0);
    chk({nm, "_pass"},  int'(b1.pass), 0);
    chk({nm, "_cnt"},   int'(b1.mism_cnt), 0);
    chk({nm, "_ffvec"}, int'(b1.first_fail_vec), 0);
    chk({nm, "_ffval"}, int'(b1.first_fail_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.start = 1'b0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0;
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // equivalent pair: full clean sweep
    mode = 0;
    go1(1'b0, 1'b1, '{lat: 17, pass: 1, cnt: 0, ffv: 0, ffval: 0});
    drain();
    chk("pass_hold", int'(b1.pass), 1);

    // stuck-at-0 minimized output: fails at 5,6,7
    mode = 1;
    go1(1'b0, 1'b1, '{lat: 17, pass: 0, cnt: 3, ffv: 5, ffval: 1});
    drain();

    // every vector mismatches; 4-bit counter reaches 8, 2-bit saturates at 3
    mode = 2;
    go1(1'b0, 1'b1, '{lat: 17, pass: 0, cnt: 8, ffv: 0, ffval: 1});
    drain();
    go2('{lat: 17, pass: 0, cnt: 3, ffv: 0, ffval: 1});
    drain();

    // abort during SAMPLE of vector 3: that compare is dropped
    mode = 2;
    go1(1'b0, 1'b0, '{lat: 0, pass: 0, cnt: 0, ffv: 0, ffval: 0});
    repeat (7) @(negedge clk);
    b1.abort = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0;
    chk_vec = 1'b0;
    chk("abort_busy",  int'(b1.busy), 0);
    chk("abort_cnt",   int'(b1.mism_cnt), 3);
    chk("abort_ffval", int'(b1.first_fail_valid), 1);
    chk("abort_ffvec", int'(b1.first_fail_vec), 0);
    chk("abort_pass",  int'(b1.pass), 0);
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", int'(b1.busy), 0);

    // clean rerun after abort, with start+abort together in IDLE
    mode = 0;
    go1(1'b1, 1'b1, '{lat: 17, pass: 1, cnt: 0, ffv: 0, ffval: 0});
    drain();

    // start re-pulsed mid-sweep is ignored
    mode = 1;
    go1(1'b0, 1'b1, '{lat: 17, pass: 0, cnt: 3, ffv: 5, ffval: 1});
    repeat (3) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    repeat (5) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    drain();

    // async reset at vector 4
    mode = 2;
    go1(1'b0, 1'b0, '{lat: 0, pass: 0, cnt: 0, ffv: 0, ffval: 0});
    repeat (8) @(negedge clk);
    chk("prereset_cnt", int'(b1.mism_cnt), 4);
    chk_vec = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean sweep after reset
    mode = 0;
    go1(1'b0, 1'b1, '{lat: 17, pass: 1, cnt: 0, ffv: 0, ffval: 0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
